// File: rtl/frame_pkg.sv
// Shared types and default raster size for the frame address sequencer.
// Optional feature macro used by this slice: FRAME_SERPENTINE_EN.
package frame_pkg;

   localparam int unsigned DEF_IMG_W = 64;
   localparam int unsigned DEF_IMG_H = 64;

   // 2'b11 is deliberately left unused and treated as illegal by the sequencer.
   typedef enum logic [1:0] {
      S_LOAD = 2'b00,
      S_FULL = 2'b01,
      S_SEND = 2'b10
   } state_t;

endpackage

// File: rtl/raster_step.sv
// Combinational next-address and last-pixel detection for one raster position.
// FRAME_SERPENTINE_EN selects right-to-left scanning of odd rows.
module raster_step #(
   parameter int unsigned IMG_W = 64,
   parameter int unsigned IMG_H = 64,
   parameter int unsigned COL_W = $clog2(IMG_W),
   parameter int unsigned ROW_W = $clog2(IMG_H)
) (
   input  logic [ROW_W-1:0] row,
   input  logic [COL_W-1:0] col,
   output logic [ROW_W-1:0] next_row,
   output logic [COL_W-1:0] next_col,
   output logic             last
);

   // Compare against the real extents so non-power-of-2 sizes wrap correctly.
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

   logic row_end;

`ifdef FRAME_SERPENTINE_EN
   logic odd_row;
   assign odd_row = row[0];

   always_comb begin
      row_end  = odd_row ? (col == '0) : (col == COL_LAST);
      next_row = row;
      next_col = odd_row ? (col - COL_W'(1)) : (col + COL_W'(1));
      last     = 1'b0;
      if (row_end) begin
         if (row == ROW_LAST) begin
            next_row = '0;
            next_col = '0;
            last     = 1'b1;
         end else begin
            // The following row runs in the opposite direction.
            next_row = row + ROW_W'(1);
            next_col = odd_row ? '0 : COL_LAST;
         end
      end
   end
`else
   always_comb begin
      row_end  = (col == COL_LAST);
      next_row = row;
      next_col = col + COL_W'(1);
      last     = 1'b0;
      if (row_end) begin
         next_col = '0;
         if (row == ROW_LAST) begin
            next_row = '0;
            last     = 1'b1;
         end else begin
            next_row = row + ROW_W'(1);
         end
      end
   end
`endif

endmodule

// File: rtl/frame_addr_sequencer.sv
// Pixel address sequencer: loads a WIDTH x HEIGHT frame, then replays it under valid/ready.
// FRAME_SERPENTINE_EN (in raster_step) switches odd rows to right-to-left order.
module frame_addr_sequencer
   import frame_pkg::*;
#(
   parameter int unsigned IMG_W = DEF_IMG_W,
   parameter int unsigned IMG_H = DEF_IMG_H,
   parameter int unsigned COL_W = $clog2(IMG_W),
   parameter int unsigned ROW_W = $clog2(IMG_H)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             rx_valid,
   input  logic             start_tx,
   input  logic             tx_ready,
   output logic [ROW_W-1:0] row,
   output logic [COL_W-1:0] col,
   output logic [ROW_W-1:0] row_lag,
   output logic [COL_W-1:0] col_lag,
   output logic             w_enable,
   output logic             frame_full,
   output logic             tx_valid,
   output logic             frame_done,
   output logic             rx_overflow
);

   state_t state_q, state_d;

   logic [ROW_W-1:0] row_q, row_lag_q, next_row;
   logic [COL_W-1:0] col_q, col_lag_q, next_col;
   logic             last_pix;
   logic             w_enable_q, w_enable_d;
   logic             frame_done_q, frame_done_d;
   logic             rx_overflow_q, rx_overflow_d;
   logic             advance;
   logic             clr_addr;

   // One stepper serves both directions; only the advance condition differs.
   raster_step #(
      .IMG_W (IMG_W),
      .IMG_H (IMG_H),
      .COL_W (COL_W),
      .ROW_W (ROW_W)
   ) u_step (
      .row      (row_q),
      .col      (col_q),
      .next_row (next_row),
      .next_col (next_col),
      .last     (last_pix)
   );

   always_comb begin
      state_d       = state_q;
      advance       = 1'b0;
      clr_addr      = 1'b0;
      w_enable_d    = 1'b0;
      frame_done_d  = 1'b0;
      rx_overflow_d = rx_overflow_q;
      case (state_q)
         S_LOAD: begin
            if (rx_valid) begin
               advance    = 1'b1;
               w_enable_d = 1'b1;
               if (last_pix) state_d = S_FULL;
            end
         end
         S_FULL: begin
            if (rx_valid) rx_overflow_d = 1'b1;
            if (start_tx) state_d = S_SEND;
         end
         S_SEND: begin
            if (rx_valid) rx_overflow_d = 1'b1;
            if (tx_ready) begin
               advance = 1'b1;
               if (last_pix) begin
                  state_d      = S_LOAD;
                  frame_done_d = 1'b1;
               end
            end
         end
         default: begin
            state_d  = S_LOAD;
            clr_addr = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= S_LOAD;
         row_q         <= '0;
         col_q         <= '0;
         row_lag_q     <= '0;
         col_lag_q     <= '0;
         w_enable_q    <= 1'b0;
         frame_done_q  <= 1'b0;
         rx_overflow_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         w_enable_q    <= w_enable_d;
         frame_done_q  <= frame_done_d;
         rx_overflow_q <= rx_overflow_d;
         if (clr_addr) begin
            row_q <= '0;
            col_q <= '0;
         end else if (advance) begin
            row_lag_q <= row_q;
            col_lag_q <= col_q;
            row_q     <= next_row;
            col_q     <= next_col;
         end
      end
   end

   assign row         = row_q;
   assign col         = col_q;
   assign row_lag     = row_lag_q;
   assign col_lag     = col_lag_q;
   assign w_enable    = w_enable_q;
   assign frame_done  = frame_done_q;
   assign rx_overflow = rx_overflow_q;
   assign frame_full  = (state_q == S_FULL);
   assign tx_valid    = (state_q == S_SEND);

endmodule

// File: tb/tb_frame_addr_sequencer.sv
// Directed bench for frame_addr_sequencer: 64x64, 5x3 and 4x2 instances.
// Honours FRAME_SERPENTINE_EN for expected scan order.
module tb_frame_addr_sequencer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset;

   // 64x64 instance
   logic       rx_valid, start_tx, tx_ready;
   logic [5:0] row, col, row_lag, col_lag;
   logic       w_enable, frame_full, tx_valid, frame_done, rx_overflow;

   // 5x3 instance
   logic       s_rx_valid;
   logic [1:0] s_row, s_row_lag;
   logic [2:0] s_col, s_col_lag;
   logic       s_w_enable, s_frame_full, s_tx_valid, s_frame_done, s_rx_overflow;

   // 4x2 instance
   logic       t_rx_valid;
   logic       t_row, t_row_lag;
   logic [1:0] t_col, t_col_lag;
   logic       t_w_enable, t_frame_full, t_tx_valid, t_frame_done, t_rx_overflow;

   int n_pass  = 0;
   int n_fail  = 0;
   int n_total = 0;

   int t_exp_r[8];
   int t_exp_c[8];

   frame_addr_sequencer dut (
      .clk         (clk),
      .reset       (reset),
      .rx_valid    (rx_valid),
      .start_tx    (start_tx),
      .tx_ready    (tx_ready),
      .row         (row),
      .col         (col),
      .row_lag     (row_lag),
      .col_lag     (col_lag),
      .w_enable    (w_enable),
      .frame_full  (frame_full),
      .tx_valid    (tx_valid),
      .frame_done  (frame_done),
      .rx_overflow (rx_overflow)
   );

   frame_addr_sequencer #(.IMG_W(5), .IMG_H(3)) dut5 (
      .clk         (clk),
      .reset       (reset),
      .rx_valid    (s_rx_valid),
      .start_tx    (1'b0),
      .tx_ready    (1'b0),
      .row         (s_row),
      .col         (s_col),
      .row_lag     (s_row_lag),
      .col_lag     (s_col_lag),
      .w_enable    (s_w_enable),
      .frame_full  (s_frame_full),
      .tx_valid    (s_tx_valid),
      .frame_done  (s_frame_done),
      .rx_overflow (s_rx_overflow)
   );

   frame_addr_sequencer #(.IMG_W(4), .IMG_H(2)) dut4 (
      .clk         (clk),
      .reset       (reset),
      .rx_valid    (t_rx_valid),
      .start_tx    (1'b0),
      .tx_ready    (1'b0),
      .row         (t_row),
      .col         (t_col),
      .row_lag     (t_row_lag),
      .col_lag     (t_col_lag),
      .w_enable    (t_w_enable),
      .frame_full  (t_frame_full),
      .tx_valid    (t_tx_valid),
      .frame_done  (t_frame_done),
      .rx_overflow (t_rx_overflow)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Raster position of the i-th pixel in a w x h frame.
   function automatic int exp_row(int i, int w, int h);
      int p;
      p = i % (w * h);
      return p / w;
   endfunction

   function automatic int exp_col(int i, int w, int h);
      int p;
      int c;
      p = i % (w * h);
      c = p % w;
`ifdef FRAME_SERPENTINE_EN
      if (((p / w) % 2) == 1) c = w - 1 - c;
`endif
      return c;
   endfunction

   initial begin
      int k;
      int c;

`ifdef FRAME_SERPENTINE_EN
      t_exp_r = '{0, 0, 0, 0, 1, 1, 1, 1};
      t_exp_c = '{0, 1, 2, 3, 3, 2, 1, 0};
`else
      t_exp_r = '{0, 0, 0, 0, 1, 1, 1, 1};
      t_exp_c = '{0, 1, 2, 3, 0, 1, 2, 3};
`endif

      reset      = 1'b1;
      rx_valid   = 1'b0;
      start_tx   = 1'b0;
      tx_ready   = 1'b0;
      s_rx_valid = 1'b0;
      t_rx_valid = 1'b0;
      repeat (3) tick();
      reset = 1'b0;

      // Reset state
      check("rst_row", row, 0);
      check("rst_col", col, 0);
      check("rst_row_lag", row_lag, 0);
      check("rst_col_lag", col_lag, 0);
      check("rst_w_enable", w_enable, 0);
      check("rst_frame_full", frame_full, 0);
      check("rst_tx_valid", tx_valid, 0);
      check("rst_frame_done", frame_done, 0);
      check("rst_rx_overflow", rx_overflow, 0);
      check("rst5_flags", {s_w_enable, s_frame_full, s_tx_valid, s_frame_done, s_rx_overflow}, 0);
      check("rst4_flags", {t_w_enable, t_frame_full, t_tx_valid, t_frame_done, t_rx_overflow}, 0);

      // start_tx in S_LOAD is ignored
      start_tx = 1'b1;
      tick();
      start_tx = 1'b0;
      check("start_in_load_tx_valid", tx_valid, 0);
      check("start_in_load_full", frame_full, 0);

      // Full 64x64 frame, back-to-back
      for (int i = 0; i < 4096; i++) begin
         rx_valid = 1'b1;
         tick();
         check("load_w_enable", w_enable, 1);
         check("load_row_lag", row_lag, exp_row(i, 64, 64));
         check("load_col_lag", col_lag, exp_col(i, 64, 64));
         check("load_row", row, exp_row(i + 1, 64, 64));
         check("load_col", col, exp_col(i + 1, 64, 64));
         check("load_frame_full", frame_full, (i == 4095) ? 1 : 0);
      end
      rx_valid = 1'b0;
      tick();
      check("full_w_enable_off", w_enable, 0);
      check("full_hold", frame_full, 1);
      check("full_row", row, 0);
      check("full_col", col, 0);

      start_tx = 1'b1;
      tick();
      start_tx = 1'b0;
      check("send_tx_valid", tx_valid, 1);
      check("send_full_off", frame_full, 0);
      check("send_row0", row, 0);
      check("send_col0", col, 0);

      // Readout with tx_ready pattern 1,0,1,... and one rx_valid intrusion
      k = 0;
      c = 0;
      while (k < 4096 && c < 20000) begin
         tx_ready = ((c % 3) != 1);
         rx_valid = (c == 5);
         tick();
         if (tx_ready) k++;
         check("send_row", row, exp_row(k, 64, 64));
         check("send_col", col, exp_col(k, 64, 64));
         check("send_row_lag", row_lag, exp_row(k + 4095, 64, 64));
         check("send_col_lag", col_lag, exp_col(k + 4095, 64, 64));
         check("send_w_enable", w_enable, 0);
         check("send_tx_valid_loop", tx_valid, (k < 4096) ? 1 : 0);
         check("send_frame_done", frame_done, (k == 4096) ? 1 : 0);
         check("send_rx_overflow", rx_overflow, (c >= 5) ? 1 : 0);
         c++;
      end
      tx_ready = 1'b0;
      rx_valid = 1'b0;
      tick();
      check("done_pulse_end", frame_done, 0);
      check("done_tx_valid", tx_valid, 0);
      check("done_full", frame_full, 0);
      check("overflow_sticky", rx_overflow, 1);

      // Back in S_LOAD: 100 pixels, then reset on the 101st
      for (int i = 0; i < 100; i++) begin
         rx_valid = 1'b1;
         tick();
         check("reload_w_enable", w_enable, 1);
         check("reload_row_lag", row_lag, exp_row(i, 64, 64));
         check("reload_col_lag", col_lag, exp_col(i, 64, 64));
      end
      reset    = 1'b1;
      rx_valid = 1'b1;
      tick();
      reset    = 1'b0;
      rx_valid = 1'b0;
      check("midrst_row", row, 0);
      check("midrst_col", col, 0);
      check("midrst_w_enable", w_enable, 0);
      check("midrst_lag", {row_lag, col_lag}, 0);
      check("midrst_overflow", rx_overflow, 0);
      check("midrst_done", frame_done, 0);
      check("midrst_full", frame_full, 0);

      for (int i = 0; i < 4096; i++) begin
         rx_valid = 1'b1;
         tick();
         check("fresh_row_lag", row_lag, exp_row(i, 64, 64));
         check("fresh_col_lag", col_lag, exp_col(i, 64, 64));
         check("fresh_frame_full", frame_full, (i == 4095) ? 1 : 0);
      end
      rx_valid = 1'b0;
      tick();

      // 5x3 non-power-of-2 wrap
      for (int i = 0; i < 15; i++) begin
         s_rx_valid = 1'b1;
         tick();
         check("s_w_enable", s_w_enable, 1);
         check("s_row_lag", s_row_lag, exp_row(i, 5, 3));
         check("s_col_lag", s_col_lag, exp_col(i, 5, 3));
         check("s_row", s_row, exp_row(i + 1, 5, 3));
         check("s_col", s_col, exp_col(i + 1, 5, 3));
         check("s_frame_full", s_frame_full, (i == 14) ? 1 : 0);
      end
      s_rx_valid = 1'b0;
      tick();
      check("s_w_enable_off", s_w_enable, 0);
      check("s_full_hold", s_frame_full, 1);
      check("s_addr_zero", {s_row, s_col}, 0);

      // 4x2 lag order from a hand-written table
      for (int i = 0; i < 8; i++) begin
         t_rx_valid = 1'b1;
         tick();
         check("t_row_lag", t_row_lag, t_exp_r[i]);
         check("t_col_lag", t_col_lag, t_exp_c[i]);
         check("t_frame_full", t_frame_full, (i == 7) ? 1 : 0);
      end
      t_rx_valid = 1'b0;
      tick();
      check("t_addr_zero", {t_row, t_col}, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
